// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the decode stage.
//
// Holds the PC, issues one instruction-memory request at a time, captures the
// returned word and presents it with its PC to the decoder over valid/ready.
// Jump redirects from execute retarget the PC; a fetch already in flight when
// a redirect arrives is marked stale and its response is dropped.
//
// Optional feature macro: IFU_HALT_EN
//   defined   : decoder end flag on a HOLD fire enters HALT (exit by reset only)
//   undefined : end flag ignored, o_ifu_halt tied to 0
//
// Ports
//   i_sys_clk, i_sys_rst_n       clock, async active-low reset
//   o_ifu_ram_req_valid/_addr    fetch request (address word aligned)
//   i_ram_req_ready              memory accepts request
//   i_ram_rsp_valid, i_ram_inst  memory response
//   o_sys_valid, i_sys_ready     decoder handshake
//   o_ifu_inst, o_ifu_pc         held instruction and its PC
//   i_exu_jmp_en, i_exu_jmp_pc   redirect pulse and target
//   i_idu_end_flag               end instruction reported for the held word
//   o_ifu_halt                   fetch halted
module ifu_fetch #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h8000_0000
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst_n,
   output logic                  o_ifu_ram_req_valid,
   input  logic                  i_ram_req_ready,
   output logic [ADDR_WIDTH-1:0] o_ifu_ram_addr,
   input  logic                  i_ram_rsp_valid,
   input  logic [INST_WIDTH-1:0] i_ram_inst,
   output logic                  o_sys_valid,
   input  logic                  i_sys_ready,
   output logic [INST_WIDTH-1:0] o_ifu_inst,
   output logic [ADDR_WIDTH-1:0] o_ifu_pc,
   input  logic                  i_exu_jmp_en,
   input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
   input  logic                  i_idu_end_flag,
   output logic                  o_ifu_halt
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [INST_WIDTH-1:0]   inst_q, inst_d;
   // Set while the outstanding request was issued for an address that a
   // redirect has since superseded; its response must not reach the decoder.
   logic                    drop_q, drop_d;
   logic [ADDR_WIDTH-1:0]   jmp_tgt;

   assign jmp_tgt = {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

`ifndef IFU_HALT_EN
   logic unused_end_flag;
   assign unused_end_flag = i_idu_end_flag;
`endif

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      drop_d  = drop_q;
      unique case (state_q)
         S_REQ: begin
            if (i_exu_jmp_en) pc_d = jmp_tgt;
            if (i_ram_req_ready) begin
               // A jump in the accept cycle still issues the old address,
               // so that response is already stale.
               state_d = S_WAIT;
               drop_d  = i_exu_jmp_en;
            end
         end
         S_WAIT: begin
            if (i_exu_jmp_en) pc_d = jmp_tgt;
            if (i_ram_rsp_valid) begin
               if (drop_q || i_exu_jmp_en) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d  = i_ram_inst;
                  state_d = S_HOLD;
               end
            end else if (i_exu_jmp_en) begin
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            // Jump beats both the +4 advance and the end flag.
            if (i_exu_jmp_en) begin
               pc_d    = jmp_tgt;
               state_d = S_REQ;
            end else if (i_sys_ready) begin
`ifdef IFU_HALT_EN
               if (i_idu_end_flag) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + ADDR_WIDTH'(4);
                  state_d = S_REQ;
               end
`else
               pc_d    = pc_q + ADDR_WIDTH'(4);
               state_d = S_REQ;
`endif
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_REQ;
      endcase
   end

   // Outputs decode registered state only.
   assign o_ifu_ram_req_valid = (state_q == S_REQ);
   assign o_ifu_ram_addr      = pc_q;
   assign o_sys_valid         = (state_q == S_HOLD);
   assign o_ifu_inst          = inst_q;
   assign o_ifu_pc            = pc_q;
`ifdef IFU_HALT_EN
   assign o_ifu_halt          = (state_q == S_HALT);
`else
   assign o_ifu_halt          = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, rsp_valid, sys_valid, sys_ready;
   logic        jmp_en, end_flag, halt;
   logic [31:0] addr, rsp_inst, inst, pc, jmp_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ifu_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .i_sys_clk          (clk),
      .i_sys_rst_n        (rst_n),
      .o_ifu_ram_req_valid(req_valid),
      .i_ram_req_ready    (req_ready),
      .o_ifu_ram_addr     (addr),
      .i_ram_rsp_valid    (rsp_valid),
      .i_ram_inst         (rsp_inst),
      .o_sys_valid        (sys_valid),
      .i_sys_ready        (sys_ready),
      .o_ifu_inst         (inst),
      .o_ifu_pc           (pc),
      .i_exu_jmp_en       (jmp_en),
      .i_exu_jmp_pc       (jmp_pc),
      .i_idu_end_flag     (end_flag),
      .o_ifu_halt         (halt)
   );

   // {req_valid, sys_valid, halt}
   wire [2:0]  ctl = {req_valid, sys_valid, halt};
   wire [98:0] obs = {req_valid, addr, sys_valid, inst, pc, halt};

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_inst = '0; sys_ready = 1'b1;
      jmp_en = 1'b0; jmp_pc = '0; end_flag = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (obs !== {1'b1, RST_PC, 1'b0, 32'h0, RST_PC, 1'b0}) begin
         n_err++; $display("FAIL reset_values: got %h want %h", obs, {1'b1, RST_PC, 1'b0, 32'h0, RST_PC, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      do_reset();
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0000) begin
         n_err++; $display("FAIL basic_req0: ctl=%b addr=%h want 100 80000000", ctl, addr);
      end
      tick();
      n_vec++;
      if (ctl !== 3'b000) begin n_err++; $display("FAIL basic_wait0: ctl=%b want 000", ctl); end
      rsp_valid = 1'b1; rsp_inst = 32'h0000_0013;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b010 || inst !== 32'h0000_0013 || pc !== 32'h8000_0000) begin
         n_err++; $display("FAIL basic_hold0: ctl=%b inst=%h pc=%h want 010 00000013 80000000", ctl, inst, pc);
      end
      tick();
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0004) begin
         n_err++; $display("FAIL basic_req1: ctl=%b addr=%h want 100 80000004", ctl, addr);
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0010_0093;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b010 || inst !== 32'h0010_0093 || pc !== 32'h8000_0004) begin
         n_err++; $display("FAIL basic_hold1: ctl=%b inst=%h pc=%h want 010 00100093 80000004", ctl, inst, pc);
      end
      tick();
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0008) begin
         n_err++; $display("FAIL basic_req2: ctl=%b addr=%h want 100 80000008", ctl, addr);
      end
   endtask

   task automatic test_stall;
      do_reset();
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'hDEAD_BEEF; sys_ready = 1'b0;
      tick();
      // spurious response during HOLD must be ignored
      rsp_inst = 32'h1111_1111;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (ctl !== 3'b010 || inst !== 32'hDEAD_BEEF || pc !== 32'h8000_0000) begin
            n_err++; $display("FAIL stall_hold%0d: ctl=%b inst=%h pc=%h want 010 deadbeef 80000000", i, ctl, inst, pc);
         end
         tick();
      end
      rsp_valid = 1'b0; sys_ready = 1'b1;
      tick();
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0004) begin
         n_err++; $display("FAIL stall_release: ctl=%b addr=%h want 100 80000004", ctl, addr);
      end
   endtask

   task automatic test_jump_wait;
      do_reset();
      tick();
      jmp_en = 1'b1; jmp_pc = 32'h8000_0103;
      tick();
      jmp_en = 1'b0;
      n_vec++;
      if (ctl !== 3'b000 || pc !== 32'h8000_0100) begin
         n_err++; $display("FAIL jwait_drop: ctl=%b pc=%h want 000 80000100", ctl, pc);
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0BAD_0BAD;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0100) begin
         n_err++; $display("FAIL jwait_redirect: ctl=%b addr=%h want 100 80000100", ctl, addr);
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0000_0055;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b010 || inst !== 32'h0000_0055 || pc !== 32'h8000_0100) begin
         n_err++; $display("FAIL jwait_target_word: ctl=%b inst=%h pc=%h want 010 00000055 80000100", ctl, inst, pc);
      end
   endtask

   task automatic test_jump_hold;
      do_reset();
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0000_00AA;
      tick();
      rsp_valid = 1'b0;
      jmp_en = 1'b1; jmp_pc = 32'h8000_0040; end_flag = 1'b1;
      tick();
      jmp_en = 1'b0; end_flag = 1'b0;
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0040) begin
         n_err++; $display("FAIL jhold_priority: ctl=%b addr=%h want 100 80000040", ctl, addr);
      end
   endtask

   task automatic test_jump_req;
      do_reset();
      req_ready = 1'b0; jmp_en = 1'b1; jmp_pc = 32'h8000_0203;
      tick();
      jmp_en = 1'b0;
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0200) begin
         n_err++; $display("FAIL jreq_noready: ctl=%b addr=%h want 100 80000200", ctl, addr);
      end
      req_ready = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h8000_0301;
      tick();
      jmp_en = 1'b0;
      n_vec++;
      if (ctl !== 3'b000 || pc !== 32'h8000_0300) begin
         n_err++; $display("FAIL jreq_ready_wait: ctl=%b pc=%h want 000 80000300", ctl, pc);
      end
      rsp_valid = 1'b1; rsp_inst = 32'h0000_0777;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_0300) begin
         n_err++; $display("FAIL jreq_stale_drop: ctl=%b addr=%h want 100 80000300", ctl, addr);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      req_ready = 1'b0; jmp_en = 1'b1; jmp_pc = 32'hFFFF_FFFF;
      tick();
      jmp_en = 1'b0; req_ready = 1'b1;
      n_vec++;
      if (addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_align: addr=%h want fffffffc", addr);
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0000_0077;
      tick();
      rsp_valid = 1'b0;
      tick();
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h0000_0000) begin
         n_err++; $display("FAIL wrap_pc: ctl=%b addr=%h want 100 00000000", ctl, addr);
      end
   endtask

   task automatic test_end_flag;
      do_reset();
      for (int w = 0; w < 2; w++) begin
         tick();
         rsp_valid = 1'b1; rsp_inst = 32'h100 + w;
         tick();
         rsp_valid = 1'b0;
         tick();
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0010_0073;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b010 || pc !== 32'h8000_0008) begin
         n_err++; $display("FAIL end_hold: ctl=%b pc=%h want 010 80000008", ctl, pc);
      end
      end_flag = 1'b1;
      tick();
      end_flag = 1'b0;
`ifdef IFU_HALT_EN
      n_vec++;
      if (ctl !== 3'b001 || pc !== 32'h8000_0008) begin
         n_err++; $display("FAIL end_halt: ctl=%b pc=%h want 001 80000008", ctl, pc);
      end
      jmp_en = 1'b1; jmp_pc = 32'h8000_0100;
      tick();
      jmp_en = 1'b0;
      tick(); tick();
      n_vec++;
      if (ctl !== 3'b001 || pc !== 32'h8000_0008) begin
         n_err++; $display("FAIL end_jump_ignored: ctl=%b pc=%h want 001 80000008", ctl, pc);
      end
`else
      n_vec++;
      if (ctl !== 3'b100 || addr !== 32'h8000_000C) begin
         n_err++; $display("FAIL end_ignored: ctl=%b addr=%h want 100 8000000c", ctl, addr);
      end
`endif
   endtask

   task automatic test_async_reset;
      do_reset();
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h1234_5678;
      tick();
      rsp_valid = 1'b0;
      tick();
      tick();
      n_vec++;
      if (ctl !== 3'b000 || inst !== 32'h1234_5678) begin
         n_err++; $display("FAIL areset_pre: ctl=%b inst=%h want 000 12345678", ctl, inst);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs !== {1'b1, RST_PC, 1'b0, 32'h0, RST_PC, 1'b0}) begin
         n_err++; $display("FAIL areset_immediate: got %h want %h", obs, {1'b1, RST_PC, 1'b0, 32'h0, RST_PC, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      // late response lands in REQ
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0000_CAFE;
      tick();
      rsp_valid = 1'b0; req_ready = 1'b1;
      n_vec++;
      if (ctl !== 3'b100 || addr !== RST_PC || inst !== 32'h0) begin
         n_err++; $display("FAIL areset_late_rsp: ctl=%b addr=%h inst=%h want 100 80000000 0", ctl, addr, inst);
      end
      tick();
      rsp_valid = 1'b1; rsp_inst = 32'h0000_F00D;
      tick();
      rsp_valid = 1'b0;
      n_vec++;
      if (ctl !== 3'b010 || inst !== 32'h0000_F00D || pc !== RST_PC) begin
         n_err++; $display("FAIL areset_refetch: ctl=%b inst=%h pc=%h want 010 0000f00d 80000000", ctl, inst, pc);
      end
   endtask

   // ---------------- random test with reference model ----------------
   // Model tracks: word requested but not back yet, whether that request
   // is stale, whether a word is held for the decoder, and halt.
   logic [31:0] m_pc, m_word;
   logic        m_busy, m_stale, m_full, m_halt;
   // memory model
   logic        mem_pend;
   logic [31:0] mem_addr;
   int          mem_dly;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic m_reqv();
      return !m_busy && !m_full && !m_halt;
   endfunction

   task automatic model_step;
      logic [31:0] tgt;
      tgt = jmp_pc & 32'hFFFF_FFFC;
      if (m_halt) begin
      end else if (m_reqv()) begin
         if (req_ready) begin m_busy = 1'b1; m_stale = jmp_en; end
         if (jmp_en) m_pc = tgt;
      end else if (m_busy) begin
         if (rsp_valid) begin
            m_busy = 1'b0;
            if (!(m_stale || jmp_en)) begin m_full = 1'b1; m_word = rsp_inst; end
            m_stale = 1'b0;
         end else if (jmp_en) begin
            m_stale = 1'b1;
         end
         if (jmp_en) m_pc = tgt;
      end else begin
         if (jmp_en) begin
            m_full = 1'b0; m_pc = tgt;
         end else if (sys_ready) begin
            m_full = 1'b0;
`ifdef IFU_HALT_EN
            if (end_flag) m_halt = 1'b1;
            else m_pc = m_pc + 32'd4;
`else
            m_pc = m_pc + 32'd4;
`endif
         end
      end
   endtask

   task automatic test_random;
      logic [98:0] exp;
      logic        acc, genuine;
      logic [31:0] acc_addr;
      for (int ch = 0; ch < 8; ch++) begin
         do_reset();
         m_pc = RST_PC; m_word = '0; m_busy = 0; m_stale = 0; m_full = 0; m_halt = 0;
         mem_pend = 0; mem_addr = '0; mem_dly = 0;
         for (int c = 0; c < 250; c++) begin
            exp = {m_reqv(), m_pc, m_full, m_word, m_pc, m_halt};
            n_vec++;
            if (obs !== exp) begin
               n_err++; $display("FAIL random ch%0d cyc%0d: got %h want %h", ch, c, obs, exp);
            end
            req_ready = ($urandom % 4) != 0;
            sys_ready = ($urandom % 2) != 0;
            jmp_en    = ($urandom % 8) == 0;
            case ($urandom % 4)
               0: jmp_pc = $urandom;
               1: jmp_pc = 32'hFFFF_FFF0 | ($urandom % 16);
               2: jmp_pc = RST_PC + ($urandom % 64);
               default: jmp_pc = $urandom;
            endcase
            end_flag = ($urandom % 20) == 0;
            genuine = 1'b0;
            if (mem_pend) begin
               if (mem_dly == 0) begin
                  rsp_valid = 1'b1; rsp_inst = mem_word(mem_addr); genuine = 1'b1;
               end else begin
                  mem_dly--; rsp_valid = 1'b0; rsp_inst = $urandom;
               end
            end else begin
               rsp_valid = ($urandom % 8) == 0;
               rsp_inst  = $urandom;
            end
            tick();
            acc      = m_reqv() && req_ready;
            acc_addr = m_pc;
            model_step();
            if (genuine) mem_pend = 1'b0;
            if (acc) begin
               mem_pend = 1'b1; mem_addr = acc_addr; mem_dly = $urandom_range(0, 2);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_jump_wait();
      test_jump_hold();
      test_jump_req();
      test_wrap();
      test_end_flag();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
